// File: rtl/vedic_pkg.sv
// Shared definitions for the sequential Urdhva Tiryagbhyam multiplier:
// FSM encoding, digit width and column-sum register sizing.
package vedic_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DIGIT_W = 2;

   // A column holds at most d products of 9. The carry settles below 3*d,
   // so the column sum plus carry stays under 12*d.
   function automatic int colsum_width(input int d);
      return $clog2(12 * d + 1);
   endfunction

endpackage

// File: rtl/vedic_digit_mul.sv
// Combinational base-4 digit multiplier (2-bit x 2-bit -> 4-bit), built from
// the vertical/crosswise partial products of a 2x2 Vedic cell.
module vedic_digit_mul
   import vedic_pkg::*;
(
   input  logic [DIGIT_W-1:0]   i_a,
   input  logic [DIGIT_W-1:0]   i_b,
   output logic [2*DIGIT_W-1:0] o_p
);

   logic w_v0, w_x0, w_x1, w_v1, w_c1;

   // Vertical terms feed bits 0 and 2; the crosswise pair feeds bit 1.
   always_comb begin
      w_v0   = i_a[0] & i_b[0];
      w_x0   = i_a[1] & i_b[0];
      w_x1   = i_a[0] & i_b[1];
      w_v1   = i_a[1] & i_b[1];
      w_c1   = w_x0 & w_x1;
      o_p[0] = w_v0;
      o_p[1] = w_x0 ^ w_x1;
      o_p[2] = w_v1 ^ w_c1;
      o_p[3] = w_v1 & w_c1;
   end

endmodule

// File: rtl/vedic_mult_seq.sv
// Multi-cycle Vedic multiplier: one crosswise column of base-4 digits per
// clock, valid/ready on both sides, optional two's-complement operands.
module vedic_mult_seq
   import vedic_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p,
   output logic               busy
);

   localparam int D    = WIDTH / 2;
   localparam int NCOL = 2 * D - 1;
   localparam int CSW  = colsum_width(D);
   localparam int CW   = $clog2(NCOL);
   localparam int PW   = 2 * WIDTH;

   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_a, r_b, w_a_mag, w_b_mag;
   logic             r_neg;
   logic [CW-1:0]    r_col;
   logic [CSW-3:0]   r_carry, w_carry_nxt;
   logic [PW-1:0]    r_result, w_result_nxt, w_p_fin, r_p;
   logic             r_in_ready, r_out_valid, r_busy, w_last;
   logic [CSW-1:0]   w_colsum, w_t;
   logic [DIGIT_W-1:0]   w_bdig [D];
   logic [2*DIGIT_W-1:0] w_prod [D];

   // Multiplier k always takes A_k; its partner B_(col-k) is zero outside the column.
   always_comb begin
      for (int k = 0; k < D; k++) begin
         w_bdig[k] = 2'b00;
         for (int j = 0; j < D; j++) begin
            if ((k + j) == int'(r_col)) w_bdig[k] = r_b[2*j +: 2];
            else                        w_bdig[k] = w_bdig[k];
         end
      end
   end

   for (genvar k = 0; k < D; k++) begin : g_dm
      vedic_digit_mul u_dm (
         .i_a (r_a[2*k +: 2]),
         .i_b (w_bdig[k]),
         .o_p (w_prod[k])
      );
   end

   // Column adder, digit write-back and final sign fix-up.
   always_comb begin
      w_colsum = {CSW{1'b0}};
      for (int k = 0; k < D; k++) w_colsum = w_colsum + CSW'(w_prod[k]);
      w_t          = w_colsum + CSW'(r_carry);
      w_carry_nxt  = w_t[CSW-1:2];
      w_last       = (r_col == CW'(NCOL - 1));
      w_result_nxt = r_result;
      for (int c = 0; c < NCOL; c++) begin
         if (c == int'(r_col)) w_result_nxt[2*c +: 2] = w_t[1:0];
         else                  w_result_nxt[2*c +: 2] = w_result_nxt[2*c +: 2];
      end
      if (w_last) w_result_nxt[PW-1 -: 2] = w_carry_nxt[1:0];
      else        w_result_nxt[PW-1 -: 2] = w_result_nxt[PW-1 -: 2];
      if (r_neg)  w_p_fin = ~w_result_nxt + PW'(1'b1);
      else        w_p_fin = w_result_nxt;
   end

   // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unchanged.
   always_comb begin
      if (signed_mode && a[WIDTH-1]) w_a_mag = ~a + WIDTH'(1'b1);
      else                           w_a_mag = a;
      if (signed_mode && b[WIDTH-1]) w_b_mag = ~b + WIDTH'(1'b1);
      else                           w_b_mag = b;
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_nxt = CALC; else w_state_nxt = IDLE;
         CALC:    if (w_last)    w_state_nxt = DONE; else w_state_nxt = CALC;
         DONE:    if (out_ready) w_state_nxt = IDLE; else w_state_nxt = DONE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // State, datapath and registered handshake outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_a         <= {WIDTH{1'b0}};
         r_b         <= {WIDTH{1'b0}};
         r_neg       <= 1'b0;
         r_col       <= {CW{1'b0}};
         r_carry     <= {(CSW-2){1'b0}};
         r_result    <= {PW{1'b0}};
         r_p         <= {PW{1'b0}};
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_in_ready  <= (w_state_nxt == IDLE);
         r_out_valid <= (w_state_nxt == DONE);
         r_busy      <= (w_state_nxt != IDLE);
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_a      <= w_a_mag;
                  r_b      <= w_b_mag;
                  r_neg    <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_col    <= {CW{1'b0}};
                  r_carry  <= {(CSW-2){1'b0}};
                  r_result <= {PW{1'b0}};
               end
            end
            CALC: begin
               r_result <= w_result_nxt;
               r_carry  <= w_carry_nxt;
               r_col    <= r_col + CW'(1'b1);
               if (w_last) r_p <= w_p_fin;
            end
            default: begin
               r_p <= r_p;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign p         = r_p;

endmodule

// File: doc/vedic_mult_seq.md
Name: vedic_mult_seq

Overview:
Parametrised, multi-cycle Vedic (Urdhva Tiryagbhyam) multiplier. It is the successor to the fixed 4x4 combinational multiplier.
- Splits WIDTH-bit operands into base-4 digits (2-bit).
- Resolves one crosswise column per clock, using a 2x2 digit multiplier array.
- Adds valid/ready handshakes on input and output, plus an optional signed (two's-complement) mode.
- Sits between operand producers and the accumulate/datapath logic in the Tiny Tapeout top level.

Parameters:
- WIDTH, 8, operand width in bits. Must be even and >= 4. Derived values: D = WIDTH/2 digits; NCOL = 2*D-1 columns.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  operands a, b and signed_mode are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- signed_mode  input  1  1 = operands are two's complement; 0 = unsigned.
- out_valid  output  1  product is valid.
- out_ready  input  1  consumer accepts the product.
- p  output  2*WIDTH  product.
- busy  output  1  high in CALC or DONE.

Behaviour:
- Reset: one clock; rst is asynchronous and active-high. While rst is high, or after it asserts at any point including mid-CALC, the block goes to IDLE:
  - in_ready=1, out_valid=0, busy=0, p=0.
  - Column counter, carry and partial result are cleared.
  - Any in-flight operation is discarded. No output is produced for it.
- FSM states: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&in_ready (the accept edge):
  - Register |a| and |b|. In signed mode, magnitude = two's-complement negate if MSB is set; otherwise use raw bits.
  - Register neg = signed_mode & (a[W-1]^b[W-1]).
  - Clear col=0, carry=0, result=0.
  - Go to CALC.
- CALC: in_ready=0. Each cycle:
  - colsum = sum of digit products A_i*B_j over all i+j=col, with 0<=i,j<D. Each digit product is 0..9.
  - t = colsum + carry.
  - result[2col+1:2col] <= t[1:0]; carry <= t>>2.
  - Size the carry/sum register for 9*D plus the maximum carry; no overflow is permitted.
  - When col==NCOL-1: the final carry goes into result[2W-1:2W-2], the sign fix is applied (p = neg ? -result : result, modulo 2^(2W)), and the FSM goes to DONE.
- DONE: out_valid=1 and p is held stable. On out_ready, go to IDLE: out_valid=0 on the next cycle, and p retains its last value.
- Latency: out_valid is first high NCOL cycles after the accept edge (7 for WIDTH=8).
- Throughput: one result per NCOL+2 cycles when out_ready is held high.
- in_ready is low in CALC and DONE. in_valid in those states is ignored; the producer must hold it.
- out_valid must not drop without out_ready. p must not change while out_valid=1.
- Most-negative operand: magnitude 2^(W-1) fits in W bits unsigned. (-2^(W-1))^2 = 2^(2W-2) must come out exact.
- Zero operands take the full latency; there is no shortcut.

Decomposition:
- Shared package vedic_pkg holds:
  - FSM state encoding: IDLE=2'd0, CALC=2'd1, DONE=2'd2.
  - Helper constants: digit width 2, and a function computing the column-sum width from D.
- One sub-module: vedic_digit_mul. It is a combinational 2-bit x 2-bit -> 4-bit multiplier and is instantiated D times per column position selected by col.
- The column-sum adder tree and the sign pre/post logic stay in vedic_mult_seq.

Test Plan:
1. WIDTH=8, unsigned, a=13, b=11, out_ready=1 -> out_valid high 7 cycles after accept, p=143 (0x008F); in_ready low throughout CALC/DONE.
2. Unsigned a=255, b=255 -> p=0xFE01. Exercises maximum column sums and final carry into the top digit.
3. Signed a=-3 (0xFD), b=5 -> p=0xFFF1 (-15). Signed a=-128 (0x80), b=-128 -> p=0x4000. Unsigned a=0x80, b=0x80 -> p=0x4000.
4. Backpressure: a=7, b=9, out_ready=0 for 5 cycles after out_valid -> p=63 held constant, out_valid stays 1, in_ready stays 0. out_ready=1 -> IDLE next cycle, in_ready=1.
5. Reset mid-operation: accept a=200, b=100, assert rst asynchronously at col=3 -> out_valid=0, in_ready=1, p=0 immediately. Next op a=6, b=7 -> p=42 with normal latency, no residue.
6. Back-to-back: in_valid held high with 3 operand pairs, out_ready=1 -> each accepted only in IDLE, results 3 in order, spacing NCOL+2 cycles. Repeat with WIDTH=4 (a=15, b=15 -> p=225, latency 3).
